// File: rtl/unified_mem_ctrl_if.sv
// Request/response bus between the two requesters (instruction fetch and
// data load/store) and the shared single-port memory controller.
interface unified_mem_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic                  i_req;
  logic [ADDR_W-1:0]     i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [DATA_W-1:0]     i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [DATA_W/8-1:0]   d_be;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_err;

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err
  );
endinterface

// File: rtl/unified_mem_ctrl.sv
// Unified instruction/data memory controller: one DEPTH x DATA_W array with
// a single access per cycle, arbitrated between an instruction-fetch port and
// a data load/store port. One transaction in flight; response LAT cycles
// after acceptance.
module unified_mem_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int LAT      = 1,
  parameter int ARB_MODE = 0
) (
  input logic               clk,
  input logic               rst,
  unified_mem_ctrl_if.slave bus
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [1:0]          wait_cnt;
  logic                last_d;      // 1 = data port was granted most recently

  logic                d_win;
  logic                i_gnt_c;
  logic                d_gnt_c;
  logic                accept;
  logic                d_in_range;
  logic                i_in_range;
  logic [ADDR_W-1:0]   acc_addr;
  logic                acc_in_range;
  logic                acc_rd;

  logic                owner_d_p0;
  logic                err_p0;
  logic [DATA_W-1:0]   rdata_p0;
  logic                vld_p1;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign d_in_range   = 32'(bus.d_addr) < 32'(DEPTH);
  assign i_in_range   = 32'(bus.i_addr) < 32'(DEPTH);
  assign accept       = i_gnt_c | d_gnt_c;
  assign acc_addr     = d_gnt_c ? bus.d_addr : bus.i_addr;
  assign acc_in_range = d_gnt_c ? d_in_range : i_in_range;
  // Writes return zero data; only reads fetch from the array.
  assign acc_rd       = !(d_gnt_c && bus.d_we);

  // Arbitration, grants and next-state; grants only in IDLE and never in reset.
  always_comb begin
    state_nxt = state;
    i_gnt_c   = 1'b0;
    d_gnt_c   = 1'b0;
    if (ARB_MODE == 0) begin
      d_win = bus.d_req;
    end else begin
      d_win = bus.d_req && (!bus.i_req || !last_d);
    end
    case (state)
      IDLE: begin
        if (!rst) begin
          d_gnt_c = d_win;
          i_gnt_c = bus.i_req && !d_win;
          if (d_gnt_c || i_gnt_c) begin
            state_nxt = (LAT == 1) ? RESP : WAIT;
          end
        end
      end
      WAIT:    if (wait_cnt == 2'(LAT - 2)) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Latency counter and last-grant tracking for round-robin.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      last_d   <= 1'b0;
    end else begin
      if (accept) last_d <= d_gnt_c;
      if (state == WAIT) wait_cnt <= wait_cnt + 2'd1;
      else               wait_cnt <= '0;
    end
  end

  // ---- stage p0: capture response at the acceptance edge ----
  // Read data is latched here so the response is independent of later writes.
  always_ff @(posedge clk) begin
    if (accept) begin
      owner_d_p0 <= d_gnt_c;
      err_p0     <= d_gnt_c && !d_in_range;
      rdata_p0   <= (acc_in_range && acc_rd) ? mem[acc_addr] : '0;
    end
  end

  // Byte-lane write commit at acceptance; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (d_gnt_c && bus.d_we && d_in_range) begin
      for (int b = 0; b < BE_W; b++) begin
        if (bus.d_be[b]) mem[bus.d_addr][8*b +: 8] <= bus.d_wdata[8*b +: 8];
      end
    end
  end

  // ---- stage p1: response presented during RESP ----
  assign vld_p1       = (state == RESP);
  assign bus.i_gnt    = i_gnt_c;
  assign bus.d_gnt    = d_gnt_c;
  assign bus.i_rvalid = vld_p1 && !owner_d_p0;
  assign bus.d_rvalid = vld_p1 && owner_d_p0;
  assign bus.i_rdata  = bus.i_rvalid ? rdata_p0 : '0;
  assign bus.d_rdata  = bus.d_rvalid ? rdata_p0 : '0;
  assign bus.d_err    = bus.d_rvalid && err_p0;

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Scoreboard bench for unified_mem_ctrl: random and directed traffic on both
// ports, a cycle-level reference model predicting grants and responses, and an
// independent monitor popping expectations whenever a response appears.
module tb_unified_mem_ctrl;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1000;
  localparam int LAT   = 3;
  localparam int ARB   = 1;
  localparam int NRAND = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  unified_mem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  unified_mem_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .LAT(LAT), .ARB_MODE(ARB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit          is_d;
    logic [DW-1:0] data;
    bit          err;
    int          due;
  } exp_t;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc    = 0;
  exp_t        sbq[$];
  logic [DW-1:0] mdl_mem [DEPTH];
  int          next_free = 0;
  bit          last_d    = 0;
  bit          log_en    = 0;
  bit          gnt_log[$];
  bit          mon_en    = 0;
  logic [DW-1:0] last_drd = '0;
  bit          last_derr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model: one transaction occupies LAT+1 cycles; arbitration by rule.
  always @(negedge clk) begin : model_p
    bit   ei, ed;
    exp_t e;
    int   a;
    ei = 0;
    ed = 0;
    if (rst) begin
      sbq.delete();
      next_free = cyc + 1;
      last_d    = 0;
    end else if (cyc >= next_free) begin
      if (bus.d_req && bus.i_req) ed = (ARB == 0) || !last_d;
      else                        ed = bus.d_req;
      ei = bus.i_req && !ed;
    end
    if (bus.i_req || bus.d_req || bus.i_gnt || bus.d_gnt) begin
      chk("i_gnt", bus.i_gnt, ei);
      chk("d_gnt", bus.d_gnt, ed);
    end
    if (ei || ed) begin
      last_d    = ed;
      next_free = cyc + LAT + 1;
      e.is_d = ed;
      e.due  = cyc + LAT;
      e.err  = 0;
      e.data = '0;
      if (ed) begin
        a     = int'(bus.d_addr);
        e.err = (a >= DEPTH);
        if (bus.d_we) begin
          if (!e.err)
            for (int b = 0; b < DW / 8; b++)
              if (bus.d_be[b]) mdl_mem[a][8*b +: 8] = bus.d_wdata[8*b +: 8];
        end else if (!e.err) begin
          e.data = mdl_mem[a];
        end
      end else begin
        a = int'(bus.i_addr);
        if (a < DEPTH) e.data = mdl_mem[a];
      end
      sbq.push_back(e);
      if (log_en) gnt_log.push_back(ed);
    end
  end

  // Monitor: compare every presented response against the scoreboard head.
  always begin : mon_p
    exp_t e;
    @(posedge clk);
    #2;
    if (mon_en) begin
      if (bus.i_rvalid || bus.d_rvalid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_rvalid", {bus.i_rvalid, bus.d_rvalid}, 2'b00);
        end else begin
          e = sbq.pop_front();
          chk("resp_port", {bus.i_rvalid, bus.d_rvalid}, e.is_d ? 2'b01 : 2'b10);
          chk("resp_cycle", cyc, e.due);
          chk("rdata", e.is_d ? bus.d_rdata : bus.i_rdata, e.data);
          chk("d_err", bus.d_err, e.err);
          chk("other_rdata", e.is_d ? bus.i_rdata : bus.d_rdata, 0);
          if (bus.d_rvalid) begin
            last_drd  = bus.d_rdata;
            last_derr = bus.d_err;
          end
        end
      end else begin
        chk("idle_outputs", {bus.d_err, bus.i_rdata | bus.d_rdata}, 0);
        if (sbq.size() > 0 && sbq[0].due < cyc) begin
          chk("missing_rvalid", cyc, sbq[0].due);
          void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic d_issue(input bit we, input logic [3:0] be, input int a, input logic [DW-1:0] wd);
    bit got;
    got = 0;
    bus.d_req = 1'b1; bus.d_we = we; bus.d_be = be;
    bus.d_addr = AW'(a); bus.d_wdata = wd;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = bus.d_gnt;
    end
    if (!got) chk("d_gnt_timeout", got, 1);
    @(posedge clk);
    #1;
    bus.d_req = 1'b0;
  endtask

  task automatic i_issue(input int a);
    bit got;
    got = 0;
    bus.i_req = 1'b1; bus.i_addr = AW'(a);
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      got = bus.i_gnt;
    end
    if (!got) chk("i_gnt_timeout", got, 1);
    @(posedge clk);
    #1;
    bus.i_req = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 50; k++) begin
      if (sbq.size() == 0) break;
      @(posedge clk);
      #3;
    end
  endtask

  initial begin
    // Requests held high through reset: no grant may appear.
    bus.i_req = 1'b1; bus.i_addr = '0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = '0;
    bus.d_addr = '0; bus.d_wdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.i_req = 1'b0; bus.d_req = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", {bus.i_rvalid, bus.d_rvalid, bus.d_err, bus.i_gnt, bus.d_gnt}, 0);
    chk("reset_rdata", {bus.i_rdata, bus.d_rdata}, 0);
    @(posedge clk);
    #1;
    mon_en = 1;

    // Fill the array so every later read has a known value.
    for (int a = 0; a < DEPTH; a++) d_issue(1'b1, 4'hF, a, $urandom);
    drain();

    // Full write, readback, partial byte write, zero-enable write.
    d_issue(1'b1, 4'hF, 5, 32'hDEADBEEF);
    d_issue(1'b0, 4'h0, 5, 32'h0);
    drain();
    chk("dir_full_write", last_drd, 32'hDEADBEEF);
    d_issue(1'b1, 4'b0101, 5, 32'h11223344);
    d_issue(1'b0, 4'h0, 5, 32'h0);
    drain();
    chk("dir_byte_en", last_drd, 32'hDE22BE44);
    d_issue(1'b1, 4'h0, 5, 32'hFFFFFFFF);
    d_issue(1'b0, 4'h0, 5, 32'h0);
    drain();
    chk("dir_be_zero", last_drd, 32'hDE22BE44);

    // Out-of-range accesses.
    d_issue(1'b0, 4'h0, 1010, 32'h0);
    drain();
    chk("oor_read", {last_derr, last_drd}, {1'b1, 32'h0});
    d_issue(1'b1, 4'hF, 1010, 32'hCAFEF00D);
    i_issue(1015);
    drain();

    // Reset during WAIT drops the response but keeps the write.
    d_issue(1'b1, 4'hF, 7, 32'hA5A50707);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    d_issue(1'b0, 4'h0, 7, 32'h0);
    drain();
    chk("rst_keeps_write", last_drd, 32'hA5A50707);

    // Both ports requesting continuously right after reset.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    log_en = 1;
    fork
      repeat (4) d_issue(1'b0, 4'h0, $urandom_range(0, DEPTH - 1), 32'h0);
      repeat (4) i_issue($urandom_range(0, DEPTH - 1));
    join
    log_en = 0;
    drain();
    chk("arb_count", gnt_log.size(), 8);
    for (int k = 0; k < 4; k++)
      chk("arb_order", gnt_log[k], (ARB == 0) ? 1'b1 : ((k % 2) == 0));

    // Random concurrent traffic on both ports.
    fork
      for (int n = 0; n < NRAND; n++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        d_issue(1'($urandom), 4'($urandom), $urandom_range(0, 1023), $urandom);
      end
      for (int n = 0; n < NRAND; n++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        i_issue($urandom_range(0, 1023));
      end
    join
    drain();

    // Sweep the whole array through the instruction port.
    for (int a = 0; a < DEPTH; a++) i_issue(a);
    drain();
    chk("queue_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
